matmul_mem_sequencer: RTL

//  Initiator for the matrix SRAM unit: reads A (MxK) and B (KxN) through their read ports, forms C = A*B

---
 rtl/matmul_mem_sequencer_pkg.sv | 16 +
 rtl/matmul_mem_sequencer_if.sv | 33 +++
 rtl/matmul_mem_sequencer_mac.sv | 23 ++
 rtl/matmul_mem_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/matmul_mem_sequencer_pkg.sv
// Shared types and helpers for the matrix multiply sequencer and the matrix memory block.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of a C element: the full product plus enough headroom for K accumulations.
    function automatic int result_width(input int dw, input int k);
        return 2 * dw + $clog2(k);
    endfunction

endpackage

// File: rtl/matmul_mem_sequencer_if.sv
// Matrix memory bus: A/B read ports with combinational read data, C write port.
interface matmul_mem_if #(
    parameter int M  = 4,
    parameter int K  = 4,
    parameter int N  = 4,
    parameter int DW = 32,
    localparam int RW = matmul_pkg::result_width(DW, K)
);
    logic [$clog2(M)-1:0] row_addr_a;
    logic [$clog2(K)-1:0] col_addr_a;
    logic [$clog2(K)-1:0] row_addr_b;
    logic [$clog2(N)-1:0] col_addr_b;
    logic [$clog2(M)-1:0] row_addr_c;
    logic [$clog2(N)-1:0] col_addr_c;
    logic                 matrix_a_re;
    logic                 matrix_b_re;
    logic                 matrix_c_we;
    logic [DW-1:0]        data_a_rd;
    logic [DW-1:0]        data_b_rd;
    logic [RW-1:0]        data_c_wr;

    modport master (
        output row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c,
        output matrix_a_re, matrix_b_re, matrix_c_we, data_c_wr,
        input  data_a_rd, data_b_rd
    );

    modport slave (
        input  row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c,
        input  matrix_a_re, matrix_b_re, matrix_c_we, data_c_wr,
        output data_a_rd, data_b_rd
    );
endinterface

// File: rtl/matmul_mem_sequencer_mac.sv
// Unsigned multiply-accumulate at full result width; clr has priority over en.
module mac_accumulator #(
    parameter int DW = 32,
    parameter int RW = 66
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [RW-1:0] acc
);
    // Accumulator register: widen both operands first so no product bits are lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + (RW'(a) * RW'(b));
    end
endmodule

// File: rtl/matmul_mem_sequencer.sv
// Sequencer computing C = A*B over the matrix memory bus, one MAC per cycle, C row-major.
//
// state | meaning
// IDLE  | waiting for start; all bus outputs 0
// MAC   | reading A(i,k), B(k,j) and accumulating; k steps each cycle
// WRITE | writing acc to C(i,j); advances j, wrapping into i
// DONE  | one-cycle completion pulse, aborted qualifies it
module matmul_mem_sequencer
    import matmul_pkg::*;
#(
    parameter int M  = 4,
    parameter int K  = 4,
    parameter int N  = 4,
    parameter int DW = 32,
    localparam int RW = result_width(DW, K)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    matmul_mem_if.master  mem
);
    localparam int IW = $clog2(M);
    localparam int KW = $clog2(K);
    localparam int JW = $clog2(N);
    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);

    state_t         state, state_nxt;
    logic [IW-1:0]  i_cnt;
    logic [KW-1:0]  k_cnt;
    logic [JW-1:0]  j_cnt;
    logic [RW-1:0]  acc;
    logic           acc_clr, acc_en;
    logic           cnt_clr, k_step, ij_step;
    logic           abort_set, abort_clr;

    mac_accumulator #(.DW(DW), .RW(RW)) u_mac (
        .clk    (clk),
        .resetn (resetn),
        .clr    (acc_clr),
        .en     (acc_en),
        .a      (mem.data_a_rd),
        .b      (mem.data_b_rd),
        .acc    (acc)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and datapath controls; stop always wins while busy.
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        cnt_clr   = 1'b0;
        k_step    = 1'b0;
        ij_step   = 1'b0;
        abort_set = 1'b0;
        abort_clr = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = MAC;
                    acc_clr   = 1'b1;
                    cnt_clr   = 1'b1;
                    abort_clr = 1'b1;
                end
            end
            MAC: begin
                if (stop) begin
                    state_nxt = DONE;
                    acc_clr   = 1'b1;
                    cnt_clr   = 1'b1;
                    abort_set = 1'b1;
                end else begin
                    acc_en = 1'b1;
                    k_step = 1'b1;
                    if (k_cnt == K_LAST)
                        state_nxt = WRITE;
                end
            end
            WRITE: begin
                acc_clr = 1'b1;
                if (stop) begin
                    state_nxt = DONE;
                    cnt_clr   = 1'b1;
                    abort_set = 1'b1;
                end else if (i_cnt == I_LAST && j_cnt == J_LAST) begin
                    state_nxt = DONE;
                    cnt_clr   = 1'b1;
                end else begin
                    state_nxt = MAC;
                    ij_step   = 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Loop counters: k innermost, then j, then i.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
        end else if (cnt_clr) begin
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
        end else if (k_step) begin
            k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
        end else if (ij_step) begin
            k_cnt <= '0;
            if (j_cnt == J_LAST) begin
                j_cnt <= '0;
                i_cnt <= i_cnt + 1'b1;
            end else begin
                j_cnt <= j_cnt + 1'b1;
            end
        end
    end

    // Abort flag: set by stop while busy, held until the next accepted start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            aborted <= 1'b0;
        else if (abort_clr)
            aborted <= 1'b0;
        else if (abort_set)
            aborted <= 1'b1;
    end

    assign busy            = (state == MAC) || (state == WRITE);
    assign done            = (state == DONE);
    assign mem.matrix_a_re = (state == MAC);
    assign mem.matrix_b_re = (state == MAC);
    // stop suppresses the write in the cycle it aborts.
    assign mem.matrix_c_we = (state == WRITE) && !stop;
    assign mem.data_c_wr   = (state == WRITE) ? acc : '0;
    assign mem.row_addr_a  = busy ? i_cnt : '0;
    assign mem.col_addr_a  = busy ? k_cnt : '0;
    assign mem.row_addr_b  = busy ? k_cnt : '0;
    assign mem.col_addr_b  = busy ? j_cnt : '0;
    assign mem.row_addr_c  = busy ? i_cnt : '0;
    assign mem.col_addr_c  = busy ? j_cnt : '0;
endmodule
